// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for a 32K x 8 asynchronous SRAM.
// It turns single-cycle ready/valid read and write requests into sequenced ce_/oe_/we_ strobes.
// A read holds ce_/oe_ low for RD_CYCLES cycles and then samples the data bus.
// A write runs setup (1 cycle), a we_ pulse (WR_CYCLES cycles) and hold (1 cycle).
// All outputs are registered. The data bus is driven only from a registered enable.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req, wr          request strobe (taken when ready=1); 1 = write, 0 = read
//   addr, wdata      request address and write data
//   ready            idle, can accept req this cycle
//   rdata, rvalid    read data (held until the next read completes); one-cycle valid pulse
//   wdone            one-cycle write-complete pulse
//   sram_ce_/oe_/we_ active-low SRAM strobes
//   sram_addr        SRAM address
//   sram_data        bidirectional SRAM data bus
module sram_ctrl #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic              sram_ce_,
  output logic              sram_oe_,
  output logic              sram_we_,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  localparam int unsigned MaxCycles = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  // The counter is loaded with N-1, so the phase ends on the edge where it reads zero.
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;

  // The enable is a register, and it is set only in the write states.
  // The controller therefore never contends with the SRAM output drivers.
  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      ready     <= 1'b1;
      rdata     <= '0;
      rvalid    <= 1'b0;
      wdone     <= 1'b0;
      sram_ce_  <= 1'b1;
      sram_oe_  <= 1'b1;
      sram_we_  <= 1'b1;
      sram_addr <= '0;
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            sram_addr <= addr;
            sram_ce_  <= 1'b0;
            ready     <= 1'b0;
            if (wr) begin
              wdata_q <= wdata;
              drive_q <= 1'b1;
              state_q <= StWrSetup;
            end else begin
              sram_oe_ <= 1'b0;
              cnt_q    <= RdLoad;
              state_q  <= StRd;
            end
          end
        end
        StRd: begin
          if (cnt_q == '0) begin
            rdata    <= sram_data;
            rvalid   <= 1'b1;
            sram_ce_ <= 1'b1;
            sram_oe_ <= 1'b1;
            ready    <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrSetup: begin
          sram_we_ <= 1'b0;
          cnt_q    <= WrLoad;
          state_q  <= StWrPulse;
        end
        StWrPulse: begin
          if (cnt_q == '0) begin
            sram_we_ <= 1'b1;
            state_q  <= StWrHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrHold: begin
          sram_ce_ <= 1'b1;
          drive_q  <= 1'b0;
          wdone    <= 1'b1;
          ready    <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Electrical invariants of the SRAM interface.
  a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (rst)
    !(!sram_oe_ && !sram_we_));
  a_drive_oe_high: assert property (@(posedge clk) disable iff (rst)
    drive_q |-> sram_oe_);
  a_ce_idle_strobes: assert property (@(posedge clk) disable iff (rst)
    sram_ce_ |-> (sram_oe_ && sram_we_));
  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (!sram_ce_ && !$past(sram_ce_)) |-> $stable(sram_addr));

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl. Two instances are used: the defaults (2/1) and a slow one (4/3).
// Each has its own behavioural asynchronous SRAM model. A reference memory array holds the
// expected contents, and the expected strobe timing is computed from the cycle counts.
module tb_sram_ctrl;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]         req, wr;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  wire  [1:0]         ready, rvalid, wdone, ce_n, oe_n, we_n;
  wire  [1:0][DW-1:0] rdata;
  wire  [1:0][AW-1:0] saddr;
  wire  [DW-1:0]      bus0, bus1;

  logic [DW-1:0] mem0 [Depth];
  logic [DW-1:0] mem1 [Depth];
  logic [DW-1:0] ref_mem [2][Depth];

  int checks = 0;
  int errors = 0;

  // Scratch results of the most recent do_op.
  logic [DW-1:0] r;
  logic          grv, gwd;
  int lat, cec, oec, wec, wef, rl, bb, ab, bo, tmo;

  always #5 clk = ~clk;

  sram_ctrl u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .wdone(wdone[0]),
    .sram_ce_(ce_n[0]), .sram_oe_(oe_n[0]), .sram_we_(we_n[0]), .sram_addr(saddr[0]),
    .sram_data(bus0)
  );

  sram_ctrl #(.RD_CYCLES(4), .WR_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .wdone(wdone[1]),
    .sram_ce_(ce_n[1]), .sram_oe_(oe_n[1]), .sram_we_(we_n[1]), .sram_addr(saddr[1]),
    .sram_data(bus1)
  );

  // Asynchronous SRAM models: they drive the bus while ce_ and oe_ are low, and write on we_ rising.
  assign bus0 = (!ce_n[0] && !oe_n[0]) ? mem0[saddr[0]] : {DW{1'bz}};
  assign bus1 = (!ce_n[1] && !oe_n[1]) ? mem1[saddr[1]] : {DW{1'bz}};
  always @(posedge we_n[0]) if (!ce_n[0]) mem0[saddr[0]] <= bus0;
  always @(posedge we_n[1]) if (!ce_n[1]) mem1[saddr[1]] <= bus1;

  function automatic int rd_cyc(input int d);
    return (d == 1) ? 4 : 2;
  endfunction

  function automatic int wr_cyc(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [DW-1:0] bus_of(input int d);
    return (d == 1) ? bus1 : bus0;
  endfunction

  function automatic logic [DW-1:0] mem_of(input int d, input logic [AW-1:0] a);
    return (d == 1) ? mem1[a] : mem0[a];
  endfunction

  // Issue one request and record the strobe activity, cycle by cycle, until rvalid or wdone.
  task automatic do_op(input int d, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] v);
    int n;
    r = '0; grv = 1'b0; gwd = 1'b0;
    lat = 0; cec = 0; oec = 0; wec = 0; wef = 0; rl = 0; bb = 0; ab = 0; bo = 0; tmo = 0;
    n = 0;
    @(negedge clk);
    while (!ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) begin
      tmo = 1;
      return;
    end
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = v;
    @(posedge clk);
    #1 req[d] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!ce_n[d]) cec++;
      if (!oe_n[d]) oec++;
      if (!we_n[d]) begin
        wec++;
        if (wef == 0) wef = k;
      end
      if (!ready[d]) rl++;
      if (w && !ce_n[d] && bus_of(d) !== v) bb++;
      if (!ce_n[d] && saddr[d] !== a) ab++;
      if (!oe_n[d] && !we_n[d]) bo++;
      if (rvalid[d] || wdone[d]) begin
        lat = k - 1; r = rdata[d]; grv = rvalid[d]; gwd = wdone[d];
        return;
      end
    end
    tmo = 1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ready[d] !== 1'b1) begin errors++;
        $display("FAIL reset_ready dut%0d: got %b want 1", d, ready[d]); end
      checks++; if ({rvalid[d], wdone[d]} !== 2'b00) begin errors++;
        $display("FAIL reset_pulses dut%0d: got %b want 00", d, {rvalid[d], wdone[d]}); end
      checks++; if (rdata[d] !== '0) begin errors++;
        $display("FAIL reset_rdata dut%0d: got %h want 00", d, rdata[d]); end
      checks++; if ({ce_n[d], oe_n[d], we_n[d]} !== 3'b111) begin errors++;
        $display("FAIL reset_strobes dut%0d: got %b want 111", d, {ce_n[d], oe_n[d], we_n[d]}); end
      checks++; if (saddr[d] !== '0) begin errors++;
        $display("FAIL reset_addr dut%0d: got %h want 0", d, saddr[d]); end
    end
  endtask

  task automatic test_write();
    do_op(0, 1'b1, 15'h0003, 8'h5A);
    ref_mem[0][3] = 8'h5A;
    checks++; if (tmo != 0 || gwd !== 1'b1 || grv !== 1'b0) begin errors++;
      $display("FAIL write_done: got tmo=%0d wdone=%b rvalid=%b want 0 1 0", tmo, gwd, grv); end
    checks++; if (lat != 3 || rl != 3) begin errors++;
      $display("FAIL write_latency: got lat=%0d ready_low=%0d want 3 3", lat, rl); end
    checks++; if (cec != 3 || oec != 0) begin errors++;
      $display("FAIL write_ce_oe: got ce=%0d oe=%0d want 3 0", cec, oec); end
    checks++; if (wec != 1 || wef != 2) begin errors++;
      $display("FAIL write_we: got cycles=%0d first=%0d want 1 2", wec, wef); end
    checks++; if (bb != 0) begin errors++;
      $display("FAIL write_bus: got %0d bad cycles want 0", bb); end
    checks++; if (mem0[3] !== 8'h5A) begin errors++;
      $display("FAIL write_mem: got %h want 5a", mem0[3]); end
    @(negedge clk);
    checks++; if (wdone[0] !== 1'b0) begin errors++;
      $display("FAIL write_pulse_width: got %b want 0", wdone[0]); end
  endtask

  task automatic test_read();
    do_op(0, 1'b0, 15'h0003, 8'h00);
    checks++; if (tmo != 0 || grv !== 1'b1 || gwd !== 1'b0) begin errors++;
      $display("FAIL read_done: got tmo=%0d rvalid=%b wdone=%b want 0 1 0", tmo, grv, gwd); end
    checks++; if (r !== 8'h5A) begin errors++;
      $display("FAIL read_data: got %h want 5a", r); end
    checks++; if (lat != 2 || cec != 2 || oec != 2) begin errors++;
      $display("FAIL read_timing: got lat=%0d ce=%0d oe=%0d want 2 2 2", lat, cec, oec); end
    checks++; if (wec != 0 || ab != 0) begin errors++;
      $display("FAIL read_we_addr: got we=%0d addr_bad=%0d want 0 0", wec, ab); end
    @(negedge clk);
    checks++; if (rvalid[0] !== 1'b0) begin errors++;
      $display("FAIL read_pulse_width: got %b want 0", rvalid[0]); end
  endtask

  task automatic test_back_to_back();
    int found, n;
    found = 0; bo = 0; bb = 0; n = 1;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 15'h7FFF; wdata[0] = 8'hA5;
    @(posedge clk);
    #1 wr[0] = 1'b0;  // req stays high; the read is queued behind the write by the requester
    for (int k = 1; k <= 20 && found == 0; k++) begin
      @(negedge clk);
      if (!oe_n[0] && !we_n[0]) bo++;
      if (!ce_n[0] && oe_n[0] && bus0 !== 8'hA5) bb++;
      if (wdone[0]) found = 1;
    end
    checks++; if (found != 1 || ready[0] !== 1'b1) begin errors++;
      $display("FAIL b2b_wdone: got found=%0d ready=%b want 1 1", found, ready[0]); end
    @(negedge clk);
    checks++; if ({ce_n[0], oe_n[0]} !== 2'b00 || saddr[0] !== 15'h7FFF) begin errors++;
      $display("FAIL b2b_accept: got ce/oe=%b addr=%h want 00 7fff", {ce_n[0], oe_n[0]},
               saddr[0]); end
    req[0] = 1'b0;
    while (!rvalid[0] && n < 20) begin
      @(negedge clk);
      if (!oe_n[0] && !we_n[0]) bo++;
      n++;
    end
    checks++; if (rvalid[0] !== 1'b1 || n != 3) begin errors++;
      $display("FAIL b2b_rvalid: got rvalid=%b cycles=%0d want 1 3", rvalid[0], n); end
    checks++; if (rdata[0] !== 8'hA5 || mem0[15'h7FFF] !== 8'hA5) begin errors++;
      $display("FAIL b2b_data: got rdata=%h mem=%h want a5 a5", rdata[0], mem0[15'h7FFF]); end
    checks++; if (bo != 0 || bb != 0) begin errors++;
      $display("FAIL b2b_bus: got overlap=%0d bus_bad=%0d want 0 0", bo, bb); end
    ref_mem[0][15'h7FFF] = 8'hA5;
  endtask

  task automatic test_ignored_req();
    logic [AW-1:0] a, b;
    logic [DW-1:0] got;
    int nrv;
    a = 15'h1234; b = 15'h0100; nrv = 0; ab = 0; cec = 0; got = '0;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = a;
    @(posedge clk);
    #1 req[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rvalid[0]) begin nrv++; got = rdata[0]; end
      if (!ce_n[0]) cec++;
      if (!ce_n[0] && saddr[0] !== a) ab++;
      if (k == 1) begin req[0] = 1'b1; wr[0] = 1'b1; addr[0] = b; wdata[0] = ~ref_mem[0][b]; end
      if (k == 2) begin req[0] = 1'b0; wr[0] = 1'b0; addr[0] = a; end
    end
    checks++; if (nrv != 1 || cec != 2) begin errors++;
      $display("FAIL ignored_count: got rvalid=%0d ce_cycles=%0d want 1 2", nrv, cec); end
    checks++; if (ab != 0) begin errors++;
      $display("FAIL ignored_addr: got %0d changes want 0", ab); end
    checks++; if (got !== ref_mem[0][a]) begin errors++;
      $display("FAIL ignored_rdata: got %h want %h", got, ref_mem[0][a]); end
    checks++; if (mem0[b] !== ref_mem[0][b]) begin errors++;
      $display("FAIL ignored_nowrite: got %h want %h", mem0[b], ref_mem[0][b]); end
  endtask

  task automatic test_reset_mid_read();
    int nrv;
    nrv = 0;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 15'h0003;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111 || ready[0] !== 1'b1) begin errors++;
      $display("FAIL midrst_strobes: got %b ready=%b want 111 1", {ce_n[0], oe_n[0], we_n[0]},
               ready[0]); end
    checks++; if (rdata[0] !== '0 || rvalid[0] !== 1'b0) begin errors++;
      $display("FAIL midrst_rdata: got %h rvalid=%b want 00 0", rdata[0], rvalid[0]); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[0]) nrv++;
    end
    checks++; if (nrv != 0) begin errors++;
      $display("FAIL midrst_no_rvalid: got %0d pulses want 0", nrv); end
    do_op(0, 1'b0, 15'h0003, 8'h00);
    checks++; if (tmo != 0 || r !== 8'h5A || lat != 2) begin errors++;
      $display("FAIL midrst_next_read: got tmo=%0d data=%h lat=%0d want 0 5a 2", tmo, r, lat); end
  endtask

  task automatic test_random(input int d, input int n);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    int            ex_lat;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, Depth - 1));
      v = DW'($urandom);
      do_op(d, w, a, v);
      ex_lat = w ? wr_cyc(d) + 2 : rd_cyc(d);
      checks++; if (tmo != 0 || grv !== !w || gwd !== w) begin errors++;
        $display("FAIL rand%0d_done op %0d: got tmo=%0d rv=%b wd=%b want 0 %b %b", d, i, tmo, grv,
                 gwd, !w, w); end
      checks++; if (lat != ex_lat || cec != ex_lat || rl != ex_lat) begin errors++;
        $display("FAIL rand%0d_timing op %0d: got lat=%0d ce=%0d rdy_low=%0d want %0d", d, i, lat,
                 cec, rl, ex_lat); end
      checks++; if (ab != 0 || bo != 0 || bb != 0) begin errors++;
        $display("FAIL rand%0d_bus op %0d: got addr_bad=%0d overlap=%0d bus_bad=%0d want 0", d, i,
                 ab, bo, bb); end
      if (w) begin
        ref_mem[d][a] = v;
        checks++; if (wec != wr_cyc(d) || wef != 2 || oec != 0) begin errors++;
          $display("FAIL rand%0d_we op %0d: got we=%0d first=%0d oe=%0d want %0d 2 0", d, i, wec,
                   wef, oec, wr_cyc(d)); end
        checks++; if (mem_of(d, a) !== v) begin errors++;
          $display("FAIL rand%0d_mem op %0d: got %h want %h", d, i, mem_of(d, a), v); end
      end else begin
        checks++; if (oec != rd_cyc(d) || wec != 0) begin errors++;
          $display("FAIL rand%0d_oe op %0d: got oe=%0d we=%0d want %0d 0", d, i, oec, wec,
                   rd_cyc(d)); end
        checks++; if (r !== ref_mem[d][a]) begin errors++;
          $display("FAIL rand%0d_rdata op %0d addr %h: got %h want %h", d, i, a, r,
                   ref_mem[d][a]); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < Depth; i++) begin
      v = DW'($urandom); mem0[i] <= v; ref_mem[0][i] = v;
      v = DW'($urandom); mem1[i] <= v; ref_mem[1][i] = v;
    end
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_write();
    test_read();
    test_back_to_back();
    test_ignored_req();
    test_reset_mid_read();
    test_random(0, 300);
    test_random(1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
